// File: rtl/a429_pkg.sv
// rtl/a429_pkg.sv - shared types, field positions and parity helper for the ARINC429 tx scheduler
package a429_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_BUSY,
    ST_SEND,
    ST_GAP
  } state_t;

  localparam logic [1:0] SRC_MAN  = 2'd0;
  localparam logic [1:0] SRC_PER  = 2'd1;
  localparam logic [1:0] SRC_ECHO = 2'd2;

  localparam int LABEL_LSB = 0;
  localparam int LABEL_MSB = 7;
  localparam int DATA_LSB  = 8;
  localparam int DATA_MSB  = 30;
  localparam int PAR_BIT   = 31;

  localparam int GAP_W = 16;
  localparam int BTO_W = 16;

  // Parity bit that makes the popcount of the whole 32-bit word odd.
  function automatic logic odd_parity(input logic [30:0] body);
    return ~^body;
  endfunction

  function automatic logic [31:0] build_word(input logic [7:0] label, input logic [22:0] data);
    logic [31:0] w;
    w = '0;
    w[LABEL_MSB:LABEL_LSB] = label;
    w[DATA_MSB:DATA_LSB] = data;
    w[PAR_BIT] = odd_parity(w[30:0]);
    return w;
  endfunction

endpackage

// File: rtl/a429_tx_sched_if.sv
// rtl/a429_tx_sched_if.sv - source request and serializer handshake bundle
interface a429_tx_sched_if;
  logic [2:0]  req;
  logic [7:0]  label0;
  logic [7:0]  label1;
  logic [7:0]  label2;
  logic [22:0] data0;
  logic [22:0] data1;
  logic [22:0] data2;
  logic [2:0]  gnt;
  logic [31:0] tx_word;
  logic        tx_start;
  logic        tx_rate;
  logic        tx_busy;

  modport master (
    output req, label0, label1, label2, data0, data1, data2, tx_busy,
    input  gnt, tx_word, tx_start, tx_rate
  );

  modport slave (
    input  req, label0, label1, label2, data0, data1, data2, tx_busy,
    output gnt, tx_word, tx_start, tx_rate
  );
endinterface

// File: rtl/a429_rr_arb.sv
// rtl/a429_rr_arb.sv - combinational 3-way round-robin arbiter starting at pointer rr
module a429_rr_arb
  import a429_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] rr,
  output logic [2:0] gnt,
  output logic [1:0] idx,
  output logic       any
);

  always_comb begin
    logic       found;
    logic [2:0] sum;
    logic [1:0] cand;
    gnt   = '0;
    idx   = SRC_MAN;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < 3; k++) begin
      sum  = {1'b0, rr} + 3'(k);
      cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/a429_tx_sched.sv
// rtl/a429_tx_sched.sv - arbitrates three word sources onto the ARINC429 serializer with busy tracking and inter-word gap
module a429_tx_sched
  import a429_pkg::*;
#(
  parameter int GAP_HI  = 2000,
  parameter int GAP_LO  = 16000,
  parameter int BUSY_TO = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 rate_sel,
  a429_tx_sched_if.slave       bus,
  output logic                 to_err,
  output logic [15:0]          word_cnt
);

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         rr;
  logic [GAP_W-1:0]   gap_cnt;
  logic [BTO_W-1:0]   bto_cnt;

  logic [2:0]         arb_gnt;
  logic [1:0]         arb_idx;
  logic               arb_any;
  logic [7:0]         sel_label;
  logic [22:0]        sel_data;
  logic               grant;
  logic               busy_timeout;
  logic               send_done;
  logic [GAP_W-1:0]   gap_load;

  a429_rr_arb u_arb (
    .req (bus.req),
    .rr  (rr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    sel_label = bus.label0;
    sel_data  = bus.data0;
    case (arb_idx)
      SRC_PER: begin
        sel_label = bus.label1;
        sel_data  = bus.data1;
      end
      SRC_ECHO: begin
        sel_label = bus.label2;
        sel_data  = bus.data2;
      end
      default: ;
    endcase
  end

  assign grant        = (state == ST_IDLE) && en && arb_any;
  assign busy_timeout = (state == ST_WAIT_BUSY) && !bus.tx_busy && (bto_cnt == BTO_W'(BUSY_TO - 1));
  assign send_done    = (state == ST_SEND) && !bus.tx_busy;
  // Gap follows the rate the word was actually sent at, not the live selector.
  assign gap_load     = bus.tx_rate ? GAP_W'(GAP_HI) : GAP_W'(GAP_LO);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (grant) state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (bus.tx_busy)       state_nxt = ST_SEND;
        else if (busy_timeout) state_nxt = ST_GAP;
      end
      ST_SEND:      if (!bus.tx_busy) state_nxt = ST_GAP;
      ST_GAP:       if (gap_cnt <= GAP_W'(1)) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      rr           <= SRC_MAN;
      gap_cnt      <= '0;
      bto_cnt      <= '0;
      bus.gnt      <= '0;
      bus.tx_start <= 1'b0;
      bus.tx_word  <= '0;
      bus.tx_rate  <= 1'b0;
      to_err       <= 1'b0;
      word_cnt     <= '0;
    end else begin
      state        <= state_nxt;
      bus.gnt      <= '0;
      bus.tx_start <= 1'b0;
      to_err       <= 1'b0;
      if (grant) begin
        bus.gnt      <= arb_gnt;
        bus.tx_start <= 1'b1;
        bus.tx_word  <= build_word(sel_label, sel_data);
        bus.tx_rate  <= rate_sel;
        rr           <= (arb_idx == SRC_ECHO) ? SRC_MAN : arb_idx + 2'd1;
        bto_cnt      <= '0;
      end
      if ((state == ST_WAIT_BUSY) && !bus.tx_busy && !busy_timeout) begin
        bto_cnt <= bto_cnt + BTO_W'(1);
      end
      if (busy_timeout) begin
        to_err  <= 1'b1;
        gap_cnt <= gap_load;
      end
      if (send_done) begin
        word_cnt <= word_cnt + 16'd1;
        gap_cnt  <= gap_load;
      end
      if (state == ST_GAP) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_a429_tx_sched.sv
// tb/tb_a429_tx_sched.sv - directed self-checking bench for a429_tx_sched
module tb_a429_tx_sched;

  localparam int GAP_HI  = 20;
  localparam int GAP_LO  = 50;
  localparam int BUSY_TO = 8;

  localparam logic [31:0] W0 = 32'h8000_0131;
  localparam logic [31:0] W1 = 32'h7FFF_FFA5;
  localparam logic [31:0] W2 = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        rate_sel;
  logic        to_err;
  logic [15:0] word_cnt;

  int errors = 0;
  int checks = 0;
  int n;

  a429_tx_sched_if bus ();

  a429_tx_sched #(
    .GAP_HI  (GAP_HI),
    .GAP_LO  (GAP_LO),
    .BUSY_TO (BUSY_TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .rate_sel (rate_sel),
    .bus      (bus.slave),
    .to_err   (to_err),
    .word_cnt (word_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input int limit, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (bus.gnt == 3'b000 && cnt < limit);
  endtask

  task automatic run_busy(input int len);
    @(negedge clk);
    bus.tx_busy = 1'b1;
    repeat (len) @(negedge clk);
    bus.tx_busy = 1'b0;
  endtask

  initial begin
    logic [2:0]  exp_gnt [4];
    logic [31:0] exp_word [4];
    exp_gnt[0]  = 3'b001; exp_word[0] = W0;
    exp_gnt[1]  = 3'b010; exp_word[1] = W1;
    exp_gnt[2]  = 3'b100; exp_word[2] = W2;
    exp_gnt[3]  = 3'b001; exp_word[3] = W0;

    rst_n       = 1'b0;
    en          = 1'b0;
    rate_sel    = 1'b0;
    bus.req     = 3'b000;
    bus.label0  = 8'h31; bus.data0 = 23'h000001;
    bus.label1  = 8'hA5; bus.data1 = 23'h7FFFFF;
    bus.label2  = 8'h00; bus.data2 = 23'h000000;
    bus.tx_busy = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_gnt",      32'(bus.gnt), 32'h0);
    chk("rst_tx_start", 32'(bus.tx_start), 32'h0);
    chk("rst_to_err",   32'(to_err), 32'h0);
    chk("rst_tx_word",  bus.tx_word, 32'h0);
    chk("rst_tx_rate",  32'(bus.tx_rate), 32'h0);
    chk("rst_word_cnt", 32'(word_cnt), 32'h0);

    // Single request from the manual source, high rate
    rst_n    = 1'b1;
    en       = 1'b1;
    rate_sel = 1'b1;
    bus.req  = 3'b001;
    @(negedge clk);
    chk("single_gnt",      32'(bus.gnt), 32'h1);
    chk("single_tx_start", 32'(bus.tx_start), 32'h1);
    chk("single_tx_word",  bus.tx_word, W0);
    chk("single_tx_rate",  32'(bus.tx_rate), 32'h1);
    bus.req = 3'b000;
    @(negedge clk);
    chk("single_gnt_pulse",   32'(bus.gnt), 32'h0);
    chk("single_start_pulse", 32'(bus.tx_start), 32'h0);
    bus.tx_busy = 1'b1;
    repeat (10) @(negedge clk);
    bus.tx_busy = 1'b0;
    @(negedge clk);
    chk("single_word_cnt", 32'(word_cnt), 32'h1);

    // Next grant waits the full high-rate gap; low rate latched at this grant
    bus.req  = 3'b010;
    rate_sel = 1'b0;
    wait_gnt(200, n);
    chk("hi_gap_spacing", 32'(n), 32'(GAP_HI + 1));
    chk("per_gnt",        32'(bus.gnt), 32'h2);
    chk("per_tx_word",    bus.tx_word, W1);
    chk("per_tx_rate",    32'(bus.tx_rate), 32'h0);
    bus.req = 3'b000;

    // rate_sel toggled mid-send must not change tx_rate or the gap length
    @(negedge clk);
    bus.tx_busy = 1'b1;
    repeat (2) @(negedge clk);
    rate_sel = 1'b1;
    repeat (3) @(negedge clk);
    chk("per_rate_hold", 32'(bus.tx_rate), 32'h0);
    bus.tx_busy = 1'b0;
    bus.req     = 3'b100;
    wait_gnt(300, n);
    chk("lo_gap_spacing", 32'(n), 32'(GAP_LO + 2));
    chk("echo_gnt",       32'(bus.gnt), 32'h4);
    chk("echo_tx_word",   bus.tx_word, W2);
    chk("echo_tx_rate",   32'(bus.tx_rate), 32'h1);
    chk("echo_word_cnt",  32'(word_cnt), 32'h2);
    bus.req = 3'b000;

    // Busy never rises: timeout
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!to_err && n < 30);
    chk("to_err_latency",  32'(n), 32'(BUSY_TO));
    chk("to_err_word_cnt", 32'(word_cnt), 32'h2);
    bus.req = 3'b111;
    @(negedge clk);
    chk("to_err_pulse", 32'(to_err), 32'h0);
    wait_gnt(200, n);
    chk("to_gap_spacing", 32'(n), 32'(GAP_HI));

    // Contention with all three sources held
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cont_gnt_%0d", i),  32'(bus.gnt), 32'(exp_gnt[i]));
      chk($sformatf("cont_word_%0d", i), bus.tx_word, exp_word[i]);
      if (i < 3) begin
        run_busy(3);
        wait_gnt(200, n);
        chk($sformatf("cont_spacing_%0d", i), 32'(n), 32'(GAP_HI + 2));
      end
    end
    chk("cont_word_cnt", 32'(word_cnt), 32'h5);

    // en dropped during SEND: word completes, no further grants
    @(negedge clk);
    bus.tx_busy = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    bus.tx_busy = 1'b0;
    @(negedge clk);
    chk("en_word_cnt", 32'(word_cnt), 32'h6);
    wait_gnt(60, n);
    chk("en_no_grant_cnt", 32'(n), 32'd60);
    chk("en_no_grant_gnt", 32'(bus.gnt), 32'h0);

    // Re-enable, advance rr to 1, then reset during GAP
    en      = 1'b1;
    bus.req = 3'b001;
    wait_gnt(10, n);
    chk("reen_latency", 32'(n), 32'd1);
    chk("reen_gnt",     32'(bus.gnt), 32'h1);
    bus.req = 3'b000;
    run_busy(3);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt",      32'(bus.gnt), 32'h0);
    chk("mid_rst_tx_start", 32'(bus.tx_start), 32'h0);
    chk("mid_rst_to_err",   32'(to_err), 32'h0);
    chk("mid_rst_tx_word",  bus.tx_word, 32'h0);
    chk("mid_rst_tx_rate",  32'(bus.tx_rate), 32'h0);
    chk("mid_rst_word_cnt", 32'(word_cnt), 32'h0);
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = 3'b101;
    @(negedge clk);
    chk("post_rst_gnt",  32'(bus.gnt), 32'h1);
    chk("post_rst_word", bus.tx_word, W0);
    bus.req = 3'b000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
